// File: rtl/gowin_tl_pkg.sv
// Shared types and helpers for the RIFFA-to-Gowin TL transmit bridge.
package gowin_tl_pkg;

  localparam int C_DW_PER_BEAT = 8;
  localparam int C_TL_DATA_W   = C_DW_PER_BEAT * 32;
  localparam int C_OFFSET_W    = 3;

  typedef struct packed {
    logic [C_TL_DATA_W-1:0]   data;
    logic                     sop;
    logic                     eop;
    logic [C_DW_PER_BEAT-1:0] mask;
  } tl_tx_beat_t;

  typedef enum logic {
    IDLE,
    IN_PKT
  } tx_frame_state_e;

  // Dwords lo..hi inclusive; an inverted range yields an empty mask.
  function automatic logic [C_DW_PER_BEAT-1:0] dw_mask(input logic [C_OFFSET_W-1:0] lo,
                                                        input logic [C_OFFSET_W-1:0] hi);
    logic [C_DW_PER_BEAT-1:0] m;
    for (int i = 0; i < C_DW_PER_BEAT; i++) begin
      m[i] = (C_OFFSET_W'(i) >= lo) && (C_OFFSET_W'(i) <= hi);
    end
    return m;
  endfunction

endpackage

// File: rtl/tl_skid_buffer.sv
// Two-entry skid buffer: output register plus one overflow register.
// Output payload is cleared whenever the output register is empty.
module tl_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_wait_i
);

  logic [W-1:0] out_q, skid_q;
  logic         out_valid_q, skid_valid_q, ready_q;
  logic         push, pop;

  assign push = in_valid_i & ready_q;
  assign pop  = out_valid_q & ~out_wait_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else if (pop || !out_valid_q) begin
      // Output slot frees up: skid has priority, otherwise take the new beat directly.
      ready_q <= 1'b1;
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (push) begin
        out_q       <= in_data_i;
        out_valid_q <= 1'b1;
      end else begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
      end
    end else if (push) begin
      skid_q       <= in_data_i;
      skid_valid_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      ready_q <= ~skid_valid_q;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_q;

endmodule

// File: rtl/tx_engine_gowin_bridge.sv
// RIFFA TX stream to Gowin PCIe TL transmit port: offset-to-mask conversion,
// framing check, skid-buffered handshake and transmitted-packet counter.
module tx_engine_gowin_bridge
  import gowin_tl_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH = 256,
  parameter int C_PKT_CNT_W      = 16
) (
  input  logic                        CLK,
  input  logic                        RST_IN,
  input  logic [C_PCI_DATA_WIDTH-1:0] TX_TLP,
  input  logic                        TX_TLP_VALID,
  input  logic                        TX_TLP_START_FLAG,
  input  logic [C_OFFSET_W-1:0]       TX_TLP_START_OFFSET,
  input  logic                        TX_TLP_END_FLAG,
  input  logic [C_OFFSET_W-1:0]       TX_TLP_END_OFFSET,
  output logic                        TX_TLP_READY,
  output logic [C_PCI_DATA_WIDTH-1:0] TL_TX_DATA,
  output logic                        TL_TX_SOP,
  output logic                        TL_TX_EOP,
  output logic [C_DW_PER_BEAT-1:0]    TL_TX_VALID,
  input  logic                        TL_TX_WAIT,
  output logic                        ERR_FRAMING,
  output logic [C_PKT_CNT_W-1:0]      PKT_COUNT
);

  tx_frame_state_e          state_q;
  logic                     err_q;
  logic [C_PKT_CNT_W-1:0]   cnt_q;
  logic                     accept, fwd_d, viol_d, out_valid, ready;
  logic [C_OFFSET_W-1:0]    lo_d, hi_d;
  logic [C_DW_PER_BEAT-1:0] mask_d;
  tl_tx_beat_t              beat_d, beat_out;

  assign accept = TX_TLP_VALID & ready;

  always_comb begin
    lo_d        = TX_TLP_START_FLAG ? TX_TLP_START_OFFSET : '0;
    hi_d        = TX_TLP_END_FLAG ? TX_TLP_END_OFFSET : C_OFFSET_W'(C_DW_PER_BEAT - 1);
    mask_d      = dw_mask(lo_d, hi_d);
    beat_d.data = TX_TLP;
    beat_d.sop  = TX_TLP_START_FLAG;
    beat_d.eop  = TX_TLP_END_FLAG;
    beat_d.mask = mask_d;
    fwd_d       = 1'b0;
    viol_d      = 1'b0;
    if (accept) begin
      if (mask_d == '0) begin
        viol_d = 1'b1;
      end else if (state_q == IDLE && !TX_TLP_START_FLAG) begin
        viol_d = 1'b1;
      end else begin
        // A restart inside a packet is flagged but still treated as a fresh packet.
        fwd_d  = 1'b1;
        viol_d = (state_q == IN_PKT) && TX_TLP_START_FLAG;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_IN) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      err_q <= viol_d;
      if (fwd_d) begin
        state_q <= TX_TLP_END_FLAG ? IDLE : IN_PKT;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_IN) begin
      cnt_q <= '0;
    end else if (out_valid && !TL_TX_WAIT && beat_out.eop) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  tl_skid_buffer #(
    .W($bits(tl_tx_beat_t))
  ) u_skid (
    .clk_i      (CLK),
    .rst_i      (RST_IN),
    .in_valid_i (fwd_d),
    .in_data_i  (beat_d),
    .in_ready_o (ready),
    .out_valid_o(out_valid),
    .out_data_o (beat_out),
    .out_wait_i (TL_TX_WAIT)
  );

  assign TX_TLP_READY = ready;
  assign TL_TX_DATA   = beat_out.data;
  assign TL_TX_SOP    = beat_out.sop;
  assign TL_TX_EOP    = beat_out.eop;
  assign TL_TX_VALID  = beat_out.mask;
  assign ERR_FRAMING  = err_q;
  assign PKT_COUNT    = cnt_q;

endmodule

// File: tb/tb_tx_engine_gowin_bridge.sv
// Bench for tx_engine_gowin_bridge: queued stimulus against a beat-level
// reference model (FIFO of presented beats, packet state, error and counter).
module tb_tx_engine_gowin_bridge;

  logic         CLK = 1'b0;
  logic         RST_IN = 1'b1;
  logic [255:0] TX_TLP = '0;
  logic         TX_TLP_VALID = 1'b0;
  logic         TX_TLP_START_FLAG = 1'b0;
  logic [2:0]   TX_TLP_START_OFFSET = '0;
  logic         TX_TLP_END_FLAG = 1'b0;
  logic [2:0]   TX_TLP_END_OFFSET = '0;
  logic         TX_TLP_READY;
  logic [255:0] TL_TX_DATA;
  logic         TL_TX_SOP, TL_TX_EOP;
  logic [7:0]   TL_TX_VALID;
  logic         TL_TX_WAIT = 1'b0;
  logic         ERR_FRAMING;
  logic [15:0]  PKT_COUNT;

  tx_engine_gowin_bridge #(
    .C_PCI_DATA_WIDTH(256),
    .C_PKT_CNT_W     (16)
  ) dut (
    .CLK                (CLK),
    .RST_IN             (RST_IN),
    .TX_TLP             (TX_TLP),
    .TX_TLP_VALID       (TX_TLP_VALID),
    .TX_TLP_START_FLAG  (TX_TLP_START_FLAG),
    .TX_TLP_START_OFFSET(TX_TLP_START_OFFSET),
    .TX_TLP_END_FLAG    (TX_TLP_END_FLAG),
    .TX_TLP_END_OFFSET  (TX_TLP_END_OFFSET),
    .TX_TLP_READY       (TX_TLP_READY),
    .TL_TX_DATA         (TL_TX_DATA),
    .TL_TX_SOP          (TL_TX_SOP),
    .TL_TX_EOP          (TL_TX_EOP),
    .TL_TX_VALID        (TL_TX_VALID),
    .TL_TX_WAIT         (TL_TX_WAIT),
    .ERR_FRAMING        (ERR_FRAMING),
    .PKT_COUNT          (PKT_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         v;
    logic [255:0] d;
    logic         sf, ef;
    logic [2:0]   so, eo;
  } stim_t;

  typedef struct {
    logic [255:0] d;
    logic         sop, eop;
    logic [7:0]   m;
  } exp_t;

  stim_t       stim_q[$];
  logic        wait_q[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  bit          in_pkt = 1'b0;
  bit          err_exp = 1'b0;
  bit          rst_last = 1'b1;
  bit          acc = 1'b0;
  logic [15:0] cnt = '0;

  function automatic stim_t mk(bit sf, bit ef, int so, int eo);
    stim_t s;
    s.v  = 1'b1;
    s.d  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    s.sf = sf;
    s.ef = ef;
    s.so = 3'(so);
    s.eo = 3'(eo);
    return s;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.v = 1'b0; s.d = '0; s.sf = 1'b0; s.ef = 1'b0; s.so = '0; s.eo = '0;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    stim_t s;
    s = (stim_q.size() > 0) ? stim_q[0] : idle();
    TX_TLP_VALID        = s.v;
    TX_TLP              = s.d;
    TX_TLP_START_FLAG   = s.sf;
    TX_TLP_START_OFFSET = s.so;
    TX_TLP_END_FLAG     = s.ef;
    TX_TLP_END_OFFSET   = s.eo;
    TL_TX_WAIT          = (wait_q.size() > 0) ? wait_q.pop_front() : 1'b0;
  endtask

  // One clock: compare at the falling edge, then advance the model to the next rising edge.
  task automatic cycle();
    bit         ready_m;
    int         lo, hi;
    logic [7:0] m;
    exp_t       e;
    @(negedge CLK);
    ready_m = !rst_last && (exp_q.size() < 2);
    if (chk_en) begin
      chk("ready", 256'(TX_TLP_READY), 256'(ready_m));
      if (exp_q.size() > 0) begin
        chk("mask", 256'(TL_TX_VALID), 256'(exp_q[0].m));
        chk("sop", 256'(TL_TX_SOP), 256'(exp_q[0].sop));
        chk("eop", 256'(TL_TX_EOP), 256'(exp_q[0].eop));
        chk("data", TL_TX_DATA, exp_q[0].d);
      end else begin
        chk("mask_idle", 256'(TL_TX_VALID), 256'(0));
        chk("sop_idle", 256'(TL_TX_SOP), 256'(0));
        chk("eop_idle", 256'(TL_TX_EOP), 256'(0));
        chk("data_idle", TL_TX_DATA, 256'(0));
      end
      chk("err", 256'(ERR_FRAMING), 256'(err_exp));
      chk("pkt_count", 256'(PKT_COUNT), 256'(cnt));
    end
    acc = 1'b0;
    if (RST_IN) begin
      exp_q.delete();
      in_pkt   = 1'b0;
      err_exp  = 1'b0;
      cnt      = '0;
      rst_last = 1'b1;
    end else begin
      if (exp_q.size() > 0 && !TL_TX_WAIT) begin
        if (exp_q[0].eop) cnt = cnt + 16'd1;
        void'(exp_q.pop_front());
      end
      err_exp = 1'b0;
      if (TX_TLP_VALID && ready_m) begin
        acc = 1'b1;
        lo  = TX_TLP_START_FLAG ? int'(TX_TLP_START_OFFSET) : 0;
        hi  = TX_TLP_END_FLAG ? int'(TX_TLP_END_OFFSET) : 7;
        m   = (lo > hi) ? 8'h00 : 8'(((1 << (hi + 1)) - 1) & ~((1 << lo) - 1));
        if (m == 8'h00 || (!in_pkt && !TX_TLP_START_FLAG)) begin
          err_exp = 1'b1;
        end else begin
          err_exp = in_pkt && TX_TLP_START_FLAG;
          e.d   = TX_TLP;
          e.sop = TX_TLP_START_FLAG;
          e.eop = TX_TLP_END_FLAG;
          e.m   = m;
          exp_q.push_back(e);
          in_pkt = !TX_TLP_END_FLAG;
        end
      end
      rst_last = 1'b0;
    end
    @(posedge CLK);
    #1;
    if (stim_q.size() > 0 && (acc || !stim_q[0].v)) void'(stim_q.pop_front());
    drive();
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL timeout cycles=%0d budget=%0d", n, budget);
    end
    cycle();
    cycle();
  endtask

  task automatic do_reset();
    stim_q.delete();
    wait_q.delete();
    RST_IN = 1'b1;
    drive();
    cycle();
    cycle();
    RST_IN = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    int len, so, eo;
    drive();
    cycle();
    chk_en = 1'b1;
    do_reset();

    // single-beat TLP, offsets 0..3
    stim_q.push_back(mk(1, 1, 0, 3));
    run(50);

    // 4-beat TLP ending at dword 5
    stim_q.push_back(mk(1, 0, 0, 0));
    stim_q.push_back(mk(0, 0, 0, 0));
    stim_q.push_back(mk(0, 0, 0, 0));
    stim_q.push_back(mk(0, 1, 0, 5));
    run(50);

    // WAIT held five cycles mid-packet with continuous input
    stim_q.push_back(mk(1, 0, 2, 0));
    for (int i = 0; i < 6; i++) stim_q.push_back(mk(0, 0, 0, 0));
    stim_q.push_back(mk(0, 1, 0, 4));
    wait_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run(100);

    // framing: no start in IDLE, then two consecutive violations
    stim_q.push_back(mk(0, 1, 0, 7));
    stim_q.push_back(idle());
    stim_q.push_back(mk(0, 0, 0, 0));
    stim_q.push_back(mk(0, 1, 0, 2));
    run(50);

    // inverted offsets on a single-beat TLP
    stim_q.push_back(mk(1, 1, 5, 2));
    stim_q.push_back(mk(1, 1, 4, 4));
    run(50);

    // restart while inside a packet
    stim_q.push_back(mk(1, 0, 1, 0));
    stim_q.push_back(mk(0, 0, 0, 0));
    stim_q.push_back(mk(1, 1, 2, 6));
    run(50);

    // randomized legal traffic with random backpressure and gaps
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(1, 5);
      so  = $urandom_range(0, 7);
      for (int b = 0; b < len; b++) begin
        eo = (len == 1) ? $urandom_range(so, 7) : $urandom_range(0, 7);
        stim_q.push_back(mk(b == 0, b == len - 1, so, eo));
        if ($urandom_range(0, 3) == 0) stim_q.push_back(idle());
      end
    end
    for (int i = 0; i < 200; i++) wait_q.push_back($urandom_range(0, 9) < 3);
    run(2000);

    // reset with a partial packet buffered
    stim_q.push_back(mk(1, 0, 0, 0));
    for (int i = 0; i < 4; i++) stim_q.push_back(mk(0, 0, 0, 0));
    for (int i = 0; i < 10; i++) wait_q.push_back(1'b1);
    for (int i = 0; i < 5; i++) cycle();
    do_reset();
    stim_q.push_back(mk(1, 1, 3, 3));
    run(50);

    // counter wrap: 65537 single-beat TLPs from a fresh reset
    do_reset();
    chk_en = 1'b0;
    for (int i = 0; i < 65537; i++) stim_q.push_back(mk(1, 1, 0, 7));
    run(70000);
    chk_en = 1'b1;
    cycle();
    chk("wrap", 256'(PKT_COUNT), 256'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
